// File: rtl/alu181_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu181_pkg
// Purpose  : Shared types and constants for the slice-serial 74181 ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu181_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Function selects; S_XOR is the same code as S_SUB but used with m=1
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;

endpackage
`default_nettype wire

// File: rtl/alu181_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu181_slice
// Purpose  : Combinational 4-bit 74181 (active-high data, active-low carry).
// Revision : 1.0 - initial release
// ============================================================================
module alu181_slice
    import alu181_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic [3:0]         i_s,
    input  logic               i_m,
    input  logic               i_cn_n,
    output logic [SLICE_W-1:0] o_f,
    output logic               o_cn4_n,
    output logic               o_x_n,
    output logic               o_y_n
);

    logic [SLICE_W-1:0] w_e;
    logic [SLICE_W-1:0] w_d;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_c;
    logic               w_c0;
    logic               w_grp_g;
    logic               w_grp_p;

    assign w_e = ~((i_a & i_b & {SLICE_W{i_s[3]}}) | (i_a & ~i_b & {SLICE_W{i_s[2]}}));
    assign w_d = ~((~i_b & {SLICE_W{i_s[1]}}) | (i_b & {SLICE_W{i_s[0]}}) | i_a);
    assign w_g = ~w_e;
    assign w_p = ~w_d;
    assign w_c0 = ~i_cn_n;

    // Flattened lookahead: every internal carry is two gate levels from inputs
    assign w_c[0] = w_c0;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c0);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c0);

    assign w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_grp_p = &w_p;

    assign o_f     = w_e ^ w_d ^ (w_c | {SLICE_W{i_m}});
    assign o_cn4_n = ~(w_grp_g | (w_grp_p & w_c0));
    assign o_x_n   = ~w_grp_p;
    assign o_y_n   = ~w_grp_g;

endmodule
`default_nettype wire

// File: rtl/alu181_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu181_seq
// Purpose  : WIDTH-bit 74181 ALU evaluated one 4-bit slice per clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu181_seq
    import alu181_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cn4_n,
    output logic             aeb,
    output logic             x_n,
    output logic             y_n
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_run;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_s;
    logic               r_m;
    logic [WIDTH-1:0]   r_f;
    logic               r_carry_n;
    logic               r_aeb;
    logic               r_p;
    logic               r_g;
    logic [IDX_W-1:0]   r_idx;

    logic [IDX_W+1:0]   w_base;
    logic [SLICE_W-1:0] w_sa;
    logic [SLICE_W-1:0] w_sb;
    logic [SLICE_W-1:0] w_sf;
    logic               w_scn4_n;
    logic               w_sx_n;
    logic               w_sy_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (r_idx == C_IDX_LAST) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept = w_in_ready & in_valid;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = (r_idx == C_IDX_LAST);

    // One slice instance, steered to bits [4k+3:4k] by the slice index
    assign w_base = {r_idx, 2'b00};
    assign w_sa   = r_a[w_base +: SLICE_W];
    assign w_sb   = r_b[w_base +: SLICE_W];

    alu181_slice u_slice (
        .i_a     (w_sa),
        .i_b     (w_sb),
        .i_s     (r_s),
        .i_m     (r_m),
        .i_cn_n  (r_carry_n),
        .o_f     (w_sf),
        .o_cn4_n (w_scn4_n),
        .o_x_n   (w_sx_n),
        .o_y_n   (w_sy_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= '0;
            r_m       <= 1'b0;
            r_f       <= '0;
            r_carry_n <= 1'b1;
            r_aeb     <= 1'b0;
            r_p       <= 1'b0;
            r_g       <= 1'b0;
            r_idx     <= '0;
        end else if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_s       <= s;
            r_m       <= m;
            r_f       <= '0;
            r_carry_n <= cn_n;
            r_aeb     <= 1'b1;
            r_p       <= 1'b1;
            r_g       <= 1'b0;
            r_idx     <= '0;
        end else if (w_run) begin
            r_f[w_base +: SLICE_W] <= w_sf;
            r_carry_n <= w_scn4_n;
            r_aeb     <= r_aeb & (&w_sf);
            r_p       <= r_p & ~w_sx_n;
            r_g       <= ~w_sy_n | (~w_sx_n & r_g);
            r_idx     <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign f         = r_f;
    assign cn4_n     = r_carry_n;
    assign aeb       = r_aeb;
    assign x_n       = ~r_p;
    assign y_n       = ~r_g;

endmodule
`default_nettype wire

// File: tb/tb_alu181_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu181_seq
// Purpose  : Self-checking bench for alu181_seq at WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu181_seq;
    import alu181_pkg::*;

    typedef struct packed {
        logic [15:0] f;
        logic        cn4_n;
        logic        aeb;
        logic        x_n;
        logic        y_n;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cn_n;
        logic [15:0] ef;
        logic        ecn4_n;
        logic        eaeb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cn_n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        cn4_n;
    logic        aeb;
    logic        x_n;
    logic        y_n;

    int n_tests = 0;
    int n_fail  = 0;

    alu181_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .cn_n      (cn_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cn4_n     (cn4_n),
        .aeb       (aeb),
        .x_n       (x_n),
        .y_n       (y_n)
    );

    always #5 clk = ~clk;

    // Datasheet function table: arithmetic is X plus Y plus carry, logic is a
    // plain boolean of A and B. X is the word propagate term, X+Y with no
    // carry-in gives the word generate.
    function automatic res_t model(input logic [15:0] ia, ib, input logic [3:0] is,
                                   input logic im, icn_n);
        logic [15:0] x, y, lf;
        logic [16:0] sum, sum0;
        res_t r;
        case (is[1:0])
            2'b00:   x = ia;
            2'b01:   x = ia | ib;
            2'b10:   x = ia | ~ib;
            default: x = 16'hFFFF;
        endcase
        case (is[3:2])
            2'b00:   y = 16'h0000;
            2'b01:   y = ia & ~ib;
            2'b10:   y = ia & ib;
            default: y = ia;
        endcase
        case (is)
            4'h0: lf = ~ia;
            4'h1: lf = ~(ia | ib);
            4'h2: lf = ~ia & ib;
            4'h3: lf = 16'h0000;
            4'h4: lf = ~(ia & ib);
            4'h5: lf = ~ib;
            4'h6: lf = ia ^ ib;
            4'h7: lf = ia & ~ib;
            4'h8: lf = ~ia | ib;
            4'h9: lf = ~(ia ^ ib);
            4'hA: lf = ib;
            4'hB: lf = ia & ib;
            4'hC: lf = 16'hFFFF;
            4'hD: lf = ia | ~ib;
            4'hE: lf = ia | ib;
            default: lf = ia;
        endcase
        sum  = {1'b0, x} + {1'b0, y} + {16'h0, ~icn_n};
        sum0 = {1'b0, x} + {1'b0, y};
        r.f     = im ? lf : sum[15:0];
        r.cn4_n = ~sum[16];
        r.aeb   = &r.f;
        r.x_n   = ~(&x);
        r.y_n   = ~sum0[16];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [15:0] ia, ib, input logic [3:0] is, input logic im, icn_n,
                         input int hold, input bit pulse, input res_t e);
        int  w;
        int  cnt;
        bit  ready_seen;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("idle_ready", in_ready, 1);
        a = ia; b = ib; s = is; m = im; cn_n = icn_n; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cnt = 0;
        ready_seen = 1'b0;
        while (!out_valid && cnt < 20) begin
            ready_seen = ready_seen | in_ready;
            in_valid = pulse && (cnt == 1);
            a = 16'($urandom); b = 16'($urandom); s = 4'($urandom);
            m = 1'($urandom); cn_n = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        chk("latency", cnt, 4);
        chk("in_ready_in_run", ready_seen, 0);
        chk("f", f, e.f);
        chk("cn4_n", cn4_n, e.cn4_n);
        chk("aeb", aeb, e.aeb);
        chk("x_n", x_n, e.x_n);
        chk("y_n", y_n, e.y_n);
        for (int h = 0; h < hold; h++) begin
            in_valid = pulse && (h == 1);
            @(posedge clk);
            @(negedge clk);
            chk("hold_stable", {out_valid, in_ready, f, cn4_n, aeb, x_n, y_n},
                {1'b1, 1'b0, e.f, e.cn4_n, e.aeb, e.x_n, e.y_n});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release", {out_valid, in_ready}, 2'b01);
    endtask

    vec_t vecs[6];
    res_t e;
    bit   seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cn_n = 1'b1;

        vecs[0] = '{16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        vecs[3] = '{16'h0005, 16'h0003, S_SUB, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[4] = '{16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b0, 16'h0FF0, 1'b1, 1'b0};
        vecs[5] = '{16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_state", {out_valid, in_ready, f, cn4_n, aeb, x_n, y_n},
            {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1});
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset", {out_valid, in_ready}, 2'b01);

        for (int i = 0; i < 6; i++) begin
            e = model(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cn_n);
            e.f     = vecs[i].ef;
            e.cn4_n = vecs[i].ecn4_n;
            e.aeb   = vecs[i].eaeb;
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cn_n, 0, 1'b0, e);
        end

        // Backpressure with in_valid pulses in RUN and DONE
        e = model(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1);
        do_op(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, 5, 1'b1, e);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("single_result", seen, 0);

        // Reset while slice 2 is pending
        a = 16'hABCD; b = 16'h1111; s = S_ADD; m = 1'b0; cn_n = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_reset_state", {out_valid, in_ready, f, cn4_n, aeb, x_n, y_n},
            {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_ready", in_ready, 1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("no_valid_after_reset", seen, 0);
        e = model(16'h8001, 16'h7FFF, S_ADD, 1'b0, 1'b0);
        do_op(16'h8001, 16'h7FFF, S_ADD, 1'b0, 1'b0, 1, 1'b0, e);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic [3:0]  rs;
            logic        rm, rc;
            ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
            rm = 1'($urandom);  rc = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            e = model(ra, rb, rs, rm, rc);
            do_op(ra, rb, rs, rm, rc, int'($urandom_range(0, 2)), 1'($urandom), e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
